// File: rtl/dmem_axil_bridge.sv
// MEM-stage data port: turns each load/store into one AXI4-Lite master transaction,
// stalls the pipeline until it completes and returns the load word shifted to byte 0.
module dmem_axil_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [3:0]        mem_w_strb,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_w_data,
  output logic [DATA_W-1:0] mem_r_data,
  output logic              mem_stall,
  output logic              bus_err,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        addr_lo_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [3:0]        wstrb_reg;
  logic              aw_done_reg;
  logic              w_done_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              bus_err_reg;

  logic              req;
  logic [6:0]        strb_shift;
  logic              misaligned;
  logic              aw_hs;
  logic              w_hs;

  assign req        = mem_r | mem_w;
  // Any enable pushed past lane 3 means the access straddles a word boundary.
  assign strb_shift = {3'b000, mem_w_strb} << mem_addr[1:0];
  assign misaligned = |strb_shift[6:4];
  assign aw_hs      = m_awvalid & m_awready;
  assign w_hs       = m_wvalid & m_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            state_next = DONE;
          end else if (mem_w) begin
            state_next = WR;
          end else begin
            state_next = RD_ADDR;
          end
        end
      end
      WR: begin
        if ((aw_done_reg | aw_hs) & (w_done_reg | w_hs)) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_bvalid) begin
          state_next = DONE;
        end
      end
      RD_ADDR: begin
        if (m_arready) begin
          state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_rvalid) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    mem_stall = 1'b0;
    case (state_reg)
      IDLE:    mem_stall = req;
      WR: begin
        m_awvalid = ~aw_done_reg;
        m_wvalid  = ~w_done_reg;
        mem_stall = 1'b1;
      end
      WR_RESP: begin
        m_bready  = 1'b1;
        mem_stall = 1'b1;
      end
      RD_ADDR: begin
        m_arvalid = 1'b1;
        mem_stall = 1'b1;
      end
      RD_DATA: begin
        m_rready  = 1'b1;
        mem_stall = 1'b1;
      end
      default: mem_stall = 1'b0;
    endcase
  end

  // Request fields are captured once in IDLE so they stay stable while valids are up.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg    <= '0;
      addr_lo_reg <= 2'b00;
      wdata_reg   <= '0;
      wstrb_reg   <= 4'b0000;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      rdata_reg   <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            addr_reg    <= {mem_addr[ADDR_W-1:2], 2'b00};
            addr_lo_reg <= mem_addr[1:0];
            wdata_reg   <= mem_w_data << {mem_addr[1:0], 3'b000};
            wstrb_reg   <= strb_shift[3:0];
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            if (misaligned) begin
              bus_err_reg <= 1'b1;
              rdata_reg   <= '0;
            end
          end
        end
        WR: begin
          if (aw_hs) aw_done_reg <= 1'b1;
          if (w_hs)  w_done_reg  <= 1'b1;
        end
        WR_RESP: begin
          if (m_bvalid && (m_bresp != 2'b00)) bus_err_reg <= 1'b1;
        end
        RD_DATA: begin
          if (m_rvalid) begin
            rdata_reg <= m_rdata >> {addr_lo_reg, 3'b000};
            if (m_rresp != 2'b00) bus_err_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_awaddr   = addr_reg;
  assign m_araddr   = addr_reg;
  assign m_wdata    = wdata_reg;
  assign m_wstrb    = wstrb_reg;
  assign mem_r_data = rdata_reg;
  assign bus_err    = bus_err_reg;

endmodule

// File: tb/tb_dmem_axil_bridge.sv
// Scoreboard bench for dmem_axil_bridge: a driver issues directed MEM-stage requests and
// queues expectations; a negedge monitor checks every AXI handshake and every completion.
module tb_dmem_axil_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r, mem_w;
  logic [3:0]  mem_w_strb;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;
  logic        mem_stall, bus_err;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  dmem_axil_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_r(mem_r), .mem_w(mem_w), .mem_w_strb(mem_w_strb), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data), .mem_stall(mem_stall), .bus_err(bus_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=%s required=none", name, what);
  endtask

  // expectation queues
  typedef struct {
    int          stall;
    bit          chk_rd;
    logic [31:0] rd;
    bit          err;
  } comp_t;

  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [31:0] ar_q[$];
  comp_t       comp_q[$];

  // slave model configuration
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;
  bit          r_block = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

  // AXI4-Lite slave: decides its outputs 2 time units after each rising edge
  initial begin
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bvalid = 1'b0; m_rvalid = 1'b0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      end else begin
        if (m_awready) m_awready = 1'b0;
        else if (m_awvalid) begin
          if (aw_cnt >= aw_delay) begin m_awready = 1'b1; aw_cnt = 0; end
          else aw_cnt++;
        end
        if (m_wready) m_wready = 1'b0;
        else if (m_wvalid) begin
          if (w_cnt >= w_delay) begin m_wready = 1'b1; w_cnt = 0; end
          else w_cnt++;
        end
        if (m_arready) m_arready = 1'b0;
        else if (m_arvalid) begin
          if (ar_cnt >= ar_delay) begin m_arready = 1'b1; ar_cnt = 0; end
          else ar_cnt++;
        end
        if (m_bvalid) m_bvalid = 1'b0;
        else if (m_bready) begin m_bvalid = 1'b1; m_bresp = cfg_bresp; end
        if (m_rvalid) m_rvalid = 1'b0;
        else if (m_rready && !r_block) begin
          m_rvalid = 1'b1; m_rdata = cfg_rdata; m_rresp = cfg_rresp;
        end
      end
    end
  end

  // monitor
  int          stall_cnt = 0;
  bit          aw_seen = 1'b0, w_seen = 1'b0;
  logic        p_awvalid = 1'b0, p_awready = 1'b0, p_wvalid = 1'b0, p_wready = 1'b0;
  logic        p_arvalid = 1'b0, p_arready = 1'b0;
  logic [31:0] p_awaddr = 32'h0, p_wdata = 32'h0, p_araddr = 32'h0;
  logic [3:0]  p_wstrb = 4'h0;

  always @(negedge clk) begin
    logic [31:0] ea;
    logic [35:0] ew;
    comp_t       c;
    if (rst) begin
      stall_cnt = 0; aw_seen = 1'b0; w_seen = 1'b0;
      p_awvalid = 1'b0; p_wvalid = 1'b0; p_arvalid = 1'b0;
    end else begin
      if (p_awvalid && !p_awready) begin
        check("aw_valid_hold", 32'(m_awvalid), 32'd1);
        check("aw_addr_stable", m_awaddr, p_awaddr);
      end
      if (p_wvalid && !p_wready) begin
        check("w_valid_hold", 32'(m_wvalid), 32'd1);
        check("w_data_stable", m_wdata, p_wdata);
        check("w_strb_stable", 32'(m_wstrb), 32'(p_wstrb));
      end
      if (p_arvalid && !p_arready) begin
        check("ar_valid_hold", 32'(m_arvalid), 32'd1);
        check("ar_addr_stable", m_araddr, p_araddr);
      end
      if (aw_seen) check("aw_no_reissue", 32'(m_awvalid), 32'd0);
      if (w_seen)  check("w_no_reissue", 32'(m_wvalid), 32'd0);
      if (m_bready) check("bready_after_aw_and_w", 32'(aw_seen && w_seen), 32'd1);

      if (m_awvalid && m_awready) begin
        if (aw_q.size() == 0) fail_event("aw_unexpected", "handshake");
        else begin ea = aw_q.pop_front(); check("awaddr", m_awaddr, ea); end
        aw_seen = 1'b1;
      end
      if (m_wvalid && m_wready) begin
        if (w_q.size() == 0) fail_event("w_unexpected", "handshake");
        else begin
          ew = w_q.pop_front();
          check("wdata", m_wdata, ew[35:4]);
          check("wstrb", 32'(m_wstrb), 32'(ew[3:0]));
        end
        w_seen = 1'b1;
      end
      if (m_arvalid && m_arready) begin
        if (ar_q.size() == 0) fail_event("ar_unexpected", "handshake");
        else begin ea = ar_q.pop_front(); check("araddr", m_araddr, ea); end
      end

      if (mem_r || mem_w) begin
        if (mem_stall) stall_cnt++;
        else begin
          n_txn++;
          if (comp_q.size() == 0) fail_event("completion_unexpected", "done");
          else begin
            c = comp_q.pop_front();
            check("stall_cycles", 32'(stall_cnt), 32'(c.stall));
            if (c.chk_rd) check("mem_r_data", mem_r_data, c.rd);
            check("bus_err", 32'(bus_err), 32'(c.err));
          end
          $display("txn %0d: r=%0d w=%0d addr=0x%08h stall=%0d mem_r_data=0x%08h bus_err=%0d",
                   n_txn, mem_r, mem_w, mem_addr, stall_cnt, mem_r_data, bus_err);
          stall_cnt = 0; aw_seen = 1'b0; w_seen = 1'b0;
        end
      end

      p_awvalid = m_awvalid; p_awready = m_awready; p_awaddr = m_awaddr;
      p_wvalid = m_wvalid; p_wready = m_wready; p_wdata = m_wdata; p_wstrb = m_wstrb;
      p_arvalid = m_arvalid; p_arready = m_arready; p_araddr = m_araddr;
    end
  end

  // driver: called just after a rising edge, returns just after the edge leaving DONE
  task automatic issue(input logic r, input logic w, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int exp_stall, input bit chk_rd, input logic [31:0] exp_rd,
                       input bit exp_err);
    comp_t c;
    bit    done;
    c.stall = exp_stall; c.chk_rd = chk_rd; c.rd = exp_rd; c.err = exp_err;
    comp_q.push_back(c);
    mem_r = r; mem_w = w; mem_w_strb = strb; mem_addr = addr; mem_w_data = data;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!mem_stall) done = 1'b1;
    end
    if (!done) fail_event("completion_timeout", "stalled_60_cycles");
    @(posedge clk);
    #1;
    mem_r = 1'b0; mem_w = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst = 1'b1; mem_r = 1'b0; mem_w = 1'b0; mem_w_strb = 4'h0;
    mem_addr = 32'h0; mem_w_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awvalid", 32'(m_awvalid), 32'd0);
    check("rst_wvalid", 32'(m_wvalid), 32'd0);
    check("rst_arvalid", 32'(m_arvalid), 32'd0);
    check("rst_bready", 32'(m_bready), 32'd0);
    check("rst_rready", 32'(m_rready), 32'd0);
    check("rst_mem_r_data", mem_r_data, 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_mem_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("idle_no_req_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;

    // SW 0xDEADBEEF to 0x100, zero-wait slave
    aw_q.push_back(32'h100); w_q.push_back({32'hDEADBEEF, 4'hF});
    issue(1'b0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 3, 1'b0, 32'h0, 1'b0);

    // SB 0xAB to 0x203, then LB back
    aw_q.push_back(32'h200); w_q.push_back({32'hAB000000, 4'h8});
    issue(1'b0, 1'b1, 4'h1, 32'h203, 32'h000000AB, 3, 1'b0, 32'h0, 1'b0);
    cfg_rdata = 32'hAB000000; ar_q.push_back(32'h200);
    issue(1'b1, 1'b0, 4'h1, 32'h203, 32'h0, 3, 1'b1, 32'h000000AB, 1'b0);

    // SW with awready delayed, wready immediate: 1 IDLE + 4 WR + 1 WR_RESP
    aw_delay = 3;
    aw_q.push_back(32'h100); w_q.push_back({32'h11223344, 4'hF});
    issue(1'b0, 1'b1, 4'hF, 32'h100, 32'h11223344, 6, 1'b0, 32'h0, 1'b0);
    aw_delay = 0;

    // SW with wready delayed, awready immediate: 1 IDLE + 3 WR + 1 WR_RESP
    w_delay = 2;
    aw_q.push_back(32'h104); w_q.push_back({32'h55667788, 4'hF});
    issue(1'b0, 1'b1, 4'hF, 32'h104, 32'h55667788, 5, 1'b0, 32'h0, 1'b0);
    w_delay = 0;

    // LW with SLVERR: data still captured, bus_err set
    cfg_rresp = 2'b10; cfg_rdata = 32'h12345678; ar_q.push_back(32'h10);
    issue(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 3, 1'b1, 32'h12345678, 1'b1);
    cfg_rresp = 2'b00;

    // OKAY accesses afterwards keep bus_err sticky
    cfg_rdata = 32'hCAFEF00D; ar_q.push_back(32'h24);
    issue(1'b1, 1'b0, 4'hF, 32'h24, 32'h0, 3, 1'b1, 32'hCAFEF00D, 1'b1);
    cfg_rdata = 32'h5A5A1234; ar_q.push_back(32'h24);
    issue(1'b1, 1'b0, 4'h3, 32'h26, 32'h0, 3, 1'b1, 32'h00005A5A, 1'b1);
    aw_q.push_back(32'h108); w_q.push_back({32'h0BADF00D, 4'hF});
    issue(1'b0, 1'b1, 4'hF, 32'h108, 32'h0BADF00D, 3, 1'b1, 32'h00005A5A, 1'b1);

    // misaligned SH and LW: no bus activity, one stall cycle, load data cleared
    issue(1'b0, 1'b1, 4'h3, 32'h103, 32'h00001234, 1, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 1'b0, 4'hF, 32'h102, 32'h0, 1, 1'b1, 32'h0, 1'b1);

    // reset while waiting in RD_DATA
    r_block = 1'b1; ar_q.push_back(32'h30);
    mem_r = 1'b1; mem_w_strb = 4'hF; mem_addr = 32'h30;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_rready) seen = 1'b1;
    end
    if (!seen) fail_event("rd_data_timeout", "no_rready");
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; mem_r = 1'b0; r_block = 1'b0;
    @(negedge clk);
    check("post_rst_rready", 32'(m_rready), 32'd0);
    check("post_rst_arvalid", 32'(m_arvalid), 32'd0);
    check("post_rst_mem_r_data", mem_r_data, 32'h0);
    check("post_rst_bus_err", 32'(bus_err), 32'd0);
    check("post_rst_stall_no_req", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;

    // LB at 0x35 after reset: whole word shifted down by one byte
    cfg_rdata = 32'h87654321; ar_q.push_back(32'h34);
    issue(1'b1, 1'b0, 4'h1, 32'h35, 32'h0, 3, 1'b1, 32'h00876543, 1'b0);

    // SB with DECERR write response
    cfg_bresp = 2'b11;
    aw_q.push_back(32'h100); w_q.push_back({32'h0000CD00, 4'h2});
    issue(1'b0, 1'b1, 4'h1, 32'h101, 32'h000000CD, 3, 1'b1, 32'h00876543, 1'b1);
    cfg_bresp = 2'b00;

    repeat (3) @(posedge clk);
    check("aw_q_drained", 32'(aw_q.size()), 32'd0);
    check("w_q_drained", 32'(w_q.size()), 32'd0);
    check("ar_q_drained", 32'(ar_q.size()), 32'd0);
    check("comp_q_drained", 32'(comp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
